// File: rtl/node_round_ctrl.sv
// node_round_ctrl: per-node round sequencer for the EER-RL cluster protocol.
// Steps a node through heartbeat relay, CH announce, timeslot assignment and
// its TDMA data slot (or CH receive window), strobing the node-info block on
// every accepted packet of the expected type and requesting transmissions.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   pkt_valid/pkt_ready  parsed-packet handshake (pkt_ready is combinational)
//   pkt_type, pkt_ts     packet type and timeslot field
//   role_i, low_E_i      role (1 = CH) and low-energy flag from node-info block
//   en_MNI, fPktType     one-cycle node-info update strobe and its packet type
//   tx_req/tx_type       transmit request (held until tx_ack) and its type
//   tx_ack               TX path accepted the request
//   phase                current state encoding
//   sched_err            one-cycle pulse on missed slot or bad timeslot
module node_round_ctrl #(
  parameter int unsigned SLOT_CYCLES = 16,
  parameter int unsigned FRAME_SLOTS = 8,
  parameter int unsigned CH_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [2:0]  pkt_type,
  input  logic [15:0] pkt_ts,
  input  logic        role_i,
  input  logic        low_E_i,
  output logic        en_MNI,
  output logic [2:0]  fPktType,
  output logic        tx_req,
  output logic [2:0]  tx_type,
  input  logic        tx_ack,
  output logic [3:0]  phase,
  output logic        sched_err
);

  localparam int unsigned CYC_W  = $clog2(SLOT_CYCLES) + 1;
  localparam int unsigned SLOT_W = $clog2(FRAME_SLOTS) + 1;
  localparam int unsigned WAIT_W = $clog2(CH_TIMEOUT) + 1;
  localparam int unsigned TS_W   = 16;

  localparam logic [2:0] PT_HB       = 3'b000;
  localparam logic [2:0] PT_CH       = 3'b001;
  localparam logic [2:0] PT_DATA_LOW = 3'b011;
  localparam logic [2:0] PT_TS       = 3'b100;
  localparam logic [2:0] PT_DATA     = 3'b101;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WAIT_HB   = 4'd1,
    HB_RELAY  = 4'd2,
    WAIT_CH   = 4'd3,
    WAIT_TS   = 4'd4,
    SLOT_WAIT = 4'd5,
    DATA_TX   = 4'd6,
    ROUND_END = 4'd7,
    CH_RX     = 4'd8
  } state_t;

  state_t              state, state_next;
  logic [CYC_W-1:0]    cyc, cyc_d;
  logic [SLOT_W-1:0]   slot, slot_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
  logic [TS_W-1:0]     ts_lat, ts_lat_d;
  logic                en_mni_d, tx_req_d, sched_err_d;
  logic [2:0]          fpkt_d, tx_type_d;
  logic                xfer, settle_done, frame_end, frame_count, frame_enter;

  // Packets are only taken in the states that wait on the parser.
  assign pkt_ready = (state == WAIT_HB) || (state == WAIT_CH) ||
                     (state == WAIT_TS) || (state == CH_RX);
  assign xfer        = pkt_valid & pkt_ready;
  assign settle_done = (wait_cnt >= WAIT_W'(2));
  assign frame_end   = (slot == SLOT_W'(FRAME_SLOTS));
  assign phase       = state;

  // Next-state, registered-output and counter next values.
  always_comb begin
    state_next  = state;
    en_mni_d    = 1'b0;
    fpkt_d      = fPktType;
    sched_err_d = 1'b0;
    ts_lat_d    = ts_lat;
    tx_req_d    = 1'b0;
    tx_type_d   = 3'b000;
    cyc_d       = cyc;
    slot_d      = slot;
    wait_cnt_d  = wait_cnt;
    frame_count = 1'b0;
    frame_enter = 1'b0;

    case (state)
      IDLE: state_next = WAIT_HB;
      WAIT_HB: begin
        if (xfer && pkt_type == PT_HB) begin
          en_mni_d   = 1'b1;
          fpkt_d     = PT_HB;
          state_next = HB_RELAY;
        end
      end
      HB_RELAY: begin
        if (tx_ack) state_next = WAIT_CH;
      end
      WAIT_CH: begin
        // A CH announce in the final timeout cycle still wins.
        if (xfer && pkt_type == PT_CH) begin
          en_mni_d   = 1'b1;
          fpkt_d     = PT_CH;
          state_next = WAIT_TS;
        end else if (wait_cnt == WAIT_W'(CH_TIMEOUT - 1)) begin
          state_next = WAIT_HB;
        end
      end
      WAIT_TS: begin
        // Role is only trusted once the node-info block has had time to update.
        if (settle_done && role_i) begin
          state_next = CH_RX;
        end else if (xfer && pkt_type == PT_TS) begin
          en_mni_d = 1'b1;
          fpkt_d   = PT_TS;
          ts_lat_d = pkt_ts;
          if (pkt_ts >= TS_W'(FRAME_SLOTS)) begin
            sched_err_d = 1'b1;
            state_next  = WAIT_HB;
          end else begin
            state_next = SLOT_WAIT;
          end
        end
      end
      SLOT_WAIT: begin
        if (TS_W'(slot) == ts_lat) state_next = DATA_TX;
      end
      DATA_TX: begin
        // Ack beats the end-of-frame deadline in the same cycle.
        if (tx_ack) begin
          en_mni_d   = 1'b1;
          fpkt_d     = PT_DATA;
          state_next = ROUND_END;
        end else if (frame_end) begin
          sched_err_d = 1'b1;
          state_next  = WAIT_HB;
        end
      end
      ROUND_END: begin
        if (frame_end) state_next = WAIT_HB;
      end
      CH_RX: begin
        if (xfer && pkt_type == PT_DATA) begin
          en_mni_d = 1'b1;
          fpkt_d   = PT_DATA;
        end
        if (frame_end) state_next = WAIT_HB;
      end
      default: state_next = IDLE;
    endcase

    // Transmit request follows the state it belongs to, so it drops with the exit.
    if (state_next == HB_RELAY) begin
      tx_req_d  = 1'b1;
      tx_type_d = PT_HB;
    end else if (state_next == DATA_TX) begin
      tx_req_d  = 1'b1;
      tx_type_d = low_E_i ? PT_DATA_LOW : PT_DATA;
    end

    // Wait counter: timeout in WAIT_CH, settle (saturating at 2) in WAIT_TS.
    if (state_next != state) begin
      wait_cnt_d = '0;
    end else if (state == WAIT_CH) begin
      wait_cnt_d = wait_cnt + WAIT_W'(1);
    end else if (state == WAIT_TS && !settle_done) begin
      wait_cnt_d = wait_cnt + WAIT_W'(1);
    end

    // Frame timer: restarts on entry to SLOT_WAIT/CH_RX, holds at frame end.
    frame_count = (state == SLOT_WAIT) || (state == DATA_TX) ||
                  (state == ROUND_END) || (state == CH_RX);
    frame_enter = (state_next != state) &&
                  ((state_next == SLOT_WAIT) || (state_next == CH_RX));
    if (frame_enter) begin
      cyc_d  = '0;
      slot_d = '0;
    end else if (frame_count && !frame_end) begin
      if (cyc == CYC_W'(SLOT_CYCLES - 1)) begin
        cyc_d  = '0;
        slot_d = slot + SLOT_W'(1);
      end else begin
        cyc_d = cyc + CYC_W'(1);
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      en_MNI    <= 1'b0;
      fPktType  <= 3'b000;
      tx_req    <= 1'b0;
      tx_type   <= 3'b000;
      sched_err <= 1'b0;
      ts_lat    <= '0;
      cyc       <= '0;
      slot      <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_next;
      en_MNI    <= en_mni_d;
      fPktType  <= fpkt_d;
      tx_req    <= tx_req_d;
      tx_type   <= tx_type_d;
      sched_err <= sched_err_d;
      ts_lat    <= ts_lat_d;
      cyc       <= cyc_d;
      slot      <= slot_d;
      wait_cnt  <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_node_round_ctrl.sv
// tb_node_round_ctrl: directed bench for node_round_ctrl.
// A vector table walks one short member round (timeslot 0); hand-written
// sequences cover slot timing, the CH receive window, the WAIT_CH timeout,
// bad/missed slots and asynchronous reset. Inputs are driven and outputs
// sampled on the falling edge.
module tb_node_round_ctrl;

  logic        clk;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [2:0]  pkt_type;
  logic [15:0] pkt_ts;
  logic        role_i;
  logic        low_E_i;
  logic        en_MNI;
  logic [2:0]  fPktType;
  logic        tx_req;
  logic [2:0]  tx_type;
  logic        tx_ack;
  logic [3:0]  phase;
  logic        sched_err;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  node_round_ctrl #(
    .SLOT_CYCLES(16),
    .FRAME_SLOTS(8),
    .CH_TIMEOUT (1024)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_type (pkt_type),
    .pkt_ts   (pkt_ts),
    .role_i   (role_i),
    .low_E_i  (low_E_i),
    .en_MNI   (en_MNI),
    .fPktType (fPktType),
    .tx_req   (tx_req),
    .tx_type  (tx_type),
    .tx_ack   (tx_ack),
    .phase    (phase),
    .sched_err(sched_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  typ;
    logic [15:0] ts;
    logic        role;
    logic        lowe;
    logic        ack;
    logic [3:0]  ph;
    logic        rdy;
    logic        en;
    logic [2:0]  fpt;
    logic        req;
    logic [2:0]  txt;
    logic        serr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic drive_pkt(input logic [2:0] t, input logic [15:0] ts);
    pkt_valid = 1'b1;
    pkt_type  = t;
    pkt_ts    = ts;
    step();
    pkt_valid = 1'b0;
    pkt_type  = 3'b000;
    pkt_ts    = 16'd0;
  endtask

  // From WAIT_HB: heartbeat, relay ack, CH announce -> first WAIT_TS cycle.
  task automatic to_wait_ts();
    drive_pkt(3'b000, 16'd0);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    drive_pkt(3'b001, 16'd0);
  endtask

  task automatic wait_phase(input string name, input logic [3:0] ph, input int lim);
    int n;
    n = 0;
    while (phase !== ph && n < lim) begin
      step();
      n++;
    end
    chk(name, 16'(phase), 16'(ph));
  endtask

  initial begin
    int s0;
    int n;

    rst = 1'b1; pkt_valid = 1'b0; pkt_type = 3'b000; pkt_ts = 16'd0;
    role_i = 1'b0; low_E_i = 1'b0; tx_ack = 1'b0;

    //             vld   typ     ts     role  lowe  ack   ph    rdy   en    fpt     req   txt     serr
    vecs[0]  = '{1'b0, 3'b000, 16'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0};
    vecs[1]  = '{1'b1, 3'b001, 16'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0};
    vecs[2]  = '{1'b1, 3'b000, 16'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 1'b0};
    vecs[3]  = '{1'b0, 3'b000, 16'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0};
    vecs[4]  = '{1'b0, 3'b000, 16'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0};
    vecs[5]  = '{1'b1, 3'b100, 16'd5, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0};
    vecs[6]  = '{1'b1, 3'b001, 16'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 3'b001, 1'b0, 3'b000, 1'b0};
    vecs[7]  = '{1'b1, 3'b100, 16'd0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 3'b100, 1'b0, 3'b000, 1'b0};
    vecs[8]  = '{1'b0, 3'b000, 16'd0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 3'b100, 1'b1, 3'b101, 1'b0};
    vecs[9]  = '{1'b0, 3'b000, 16'd0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 3'b100, 1'b1, 3'b011, 1'b0};
    vecs[10] = '{1'b0, 3'b000, 16'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0};
    vecs[11] = '{1'b0, 3'b000, 16'd0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 3'b101, 1'b0, 3'b000, 1'b0};

    // Reset state
    repeat (3) step();
    chk("rst_phase", 16'(phase), 16'd0);
    chk("rst_txreq", 16'(tx_req), 16'd0);
    chk("rst_en", 16'(en_MNI), 16'd0);
    chk("rst_fpt", 16'(fPktType), 16'd0);
    chk("rst_serr", 16'(sched_err), 16'd0);
    chk("rst_ready", 16'(pkt_ready), 16'd0);
    rst = 1'b0;

    // Table: one member round with timeslot 0
    s0 = 0;
    for (int i = 0; i < 12; i++) begin
      pkt_valid = vecs[i].vld;
      pkt_type  = vecs[i].typ;
      pkt_ts    = vecs[i].ts;
      role_i    = vecs[i].role;
      low_E_i   = vecs[i].lowe;
      tx_ack    = vecs[i].ack;
      step();
      if (i == 7) s0 = cyc_n;
      chk($sformatf("v%0d_phase", i), 16'(phase), 16'(vecs[i].ph));
      chk($sformatf("v%0d_ready", i), 16'(pkt_ready), 16'(vecs[i].rdy));
      chk($sformatf("v%0d_en", i), 16'(en_MNI), 16'(vecs[i].en));
      chk($sformatf("v%0d_fpt", i), 16'(fPktType), 16'(vecs[i].fpt));
      chk($sformatf("v%0d_txreq", i), 16'(tx_req), 16'(vecs[i].req));
      chk($sformatf("v%0d_txtype", i), 16'(tx_type), 16'(vecs[i].txt));
      chk($sformatf("v%0d_serr", i), 16'(sched_err), 16'(vecs[i].serr));
    end
    pkt_valid = 1'b0; pkt_type = 3'b000; pkt_ts = 16'd0;
    low_E_i = 1'b0; tx_ack = 1'b0;
    wait_phase("v_round_end", 4'd1, 200);
    chk("v_round_len", 16'(cyc_n - s0), 16'd129);

    // T2: member path with timeslot 3
    to_wait_ts();
    drive_pkt(3'b100, 16'd3);
    s0 = cyc_n;
    chk("t2_slot_wait", 16'(phase), 16'd5);
    n = 0;
    while (!tx_req && n < 80) begin
      step();
      n++;
    end
    chk("t2_txreq_rise", 16'(cyc_n - s0), 16'd49);
    chk("t2_txtype", 16'(tx_type), 16'b101);
    chk("t2_phase_tx", 16'(phase), 16'd6);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    chk("t2_ack_en", 16'(en_MNI), 16'd1);
    chk("t2_ack_fpt", 16'(fPktType), 16'b101);
    chk("t2_ack_txreq", 16'(tx_req), 16'd0);
    chk("t2_round_end", 16'(phase), 16'd7);
    wait_phase("t2_back_hb", 4'd1, 200);
    chk("t2_round_len", 16'(cyc_n - s0), 16'd129);

    // T3: CH path, role ignored for the first two WAIT_TS cycles
    to_wait_ts();
    role_i = 1'b1;
    step();
    chk("t3_settle0", 16'(phase), 16'd4);
    step();
    chk("t3_settle1", 16'(phase), 16'd4);
    step();
    chk("t3_ch_rx", 16'(phase), 16'd8);
    s0 = cyc_n;
    pkt_valid = 1'b1; pkt_type = 3'b101;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t3_pulse%0d", k), 16'(en_MNI), 16'd1);
      chk($sformatf("t3_fpt%0d", k), 16'(fPktType), 16'b101);
    end
    pkt_valid = 1'b0; pkt_type = 3'b000;
    step();
    chk("t3_pulse_end", 16'(en_MNI), 16'd0);
    role_i = 1'b0;
    wait_phase("t3_back_hb", 4'd1, 200);
    chk("t3_window_len", 16'(cyc_n - s0), 16'd129);

    // T4: CH announce timeout, then announce in the last timeout cycle
    drive_pkt(3'b000, 16'd0);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    repeat (1023) step();
    chk("t4_before_to", 16'(phase), 16'd3);
    step();
    chk("t4_timeout", 16'(phase), 16'd1);
    drive_pkt(3'b000, 16'd0);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    repeat (1023) step();
    drive_pkt(3'b001, 16'd0);
    chk("t4_late_ch", 16'(phase), 16'd4);
    chk("t4_late_en", 16'(en_MNI), 16'd1);

    // T5: out-of-range timeslot
    drive_pkt(3'b100, 16'd8);
    chk("t5_serr", 16'(sched_err), 16'd1);
    chk("t5_phase", 16'(phase), 16'd1);
    chk("t5_txreq", 16'(tx_req), 16'd0);
    step();
    chk("t5_serr_pulse", 16'(sched_err), 16'd0);
    chk("t5_txreq2", 16'(tx_req), 16'd0);

    // T6: last slot, low energy, ack withheld
    to_wait_ts();
    low_E_i = 1'b1;
    drive_pkt(3'b100, 16'd7);
    s0 = cyc_n;
    n = 0;
    while (!tx_req && n < 200) begin
      step();
      n++;
    end
    chk("t6_txreq_rise", 16'(cyc_n - s0), 16'd113);
    chk("t6_txtype_low", 16'(tx_type), 16'b011);
    n = 0;
    while (!sched_err && n < 40) begin
      step();
      n++;
    end
    chk("t6_serr_time", 16'(cyc_n - s0), 16'd129);
    chk("t6_txreq_drop", 16'(tx_req), 16'd0);
    chk("t6_phase", 16'(phase), 16'd1);
    step();
    chk("t6_serr_pulse", 16'(sched_err), 16'd0);
    low_E_i = 1'b0;

    // T1: asynchronous reset during HB_RELAY
    drive_pkt(3'b000, 16'd0);
    chk("t1_relay", 16'(phase), 16'd2);
    chk("t1_txreq_pre", 16'(tx_req), 16'd1);
    rst = 1'b1;
    #1;
    chk("t1_txreq_async", 16'(tx_req), 16'd0);
    chk("t1_phase_async", 16'(phase), 16'd0);
    step();
    step();
    rst = 1'b0;
    chk("t1_phase_rel", 16'(phase), 16'd0);
    step();
    chk("t1_phase_after", 16'(phase), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
